// File: rtl/tow_pkg.sv
// Shared types and constants for the Tug-of-War match scorekeeper.
package tow_pkg;

   typedef enum logic [1:0] {PLAY, ROUND_END, MATCH_OVER} score_state_t;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_LEFT  = 2'b10;
   localparam logic [1:0] WIN_RIGHT = 2'b01;

endpackage

// File: rtl/bcd_digit.sv
// Single BCD score digit: synchronous clear beats increment, saturates at 9.
module bcd_digit
   import tow_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic inc,
   output bcd_t q
);

   bcd_t cnt_q, cnt_d;

   // Next count: clear first, otherwise increment unless already at BCD_MAX.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != BCD_MAX)) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/tow_score_counter.sv
// Tug-of-War match scorekeeper: per-player BCD scores, round reset and winner.
module tow_score_counter
   import tow_pkg::*;
#(
   parameter int unsigned WIN_TARGET = 7
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       left_win,
   input  logic       right_win,
   input  logic       restart,
   output bcd_t       left_bcd,
   output bcd_t       right_bcd,
   output logic       round_rst,
   output logic       match_over,
   output logic [1:0] winner
);

   if ((WIN_TARGET < 1) || (WIN_TARGET > 9)) begin : g_bad_target
      $error("tow_score_counter: WIN_TARGET must be in 1..9");
   end

   localparam bcd_t WIN_BCD = bcd_t'(WIN_TARGET);

   score_state_t state_q, state_d;
   logic         l_prev_q, r_prev_q;
   logic         l_rise, r_rise;
   logic [1:0]   winner_q, winner_d;
   logic         match_over_q, match_over_d;
   logic         round_rst_q, round_rst_d;
   logic         score_clr, l_inc, r_inc;

   // prev regs reset high so a win level already asserted at reset release is not a rise.
   assign l_rise = left_win & ~l_prev_q;
   assign r_rise = right_win & ~r_prev_q;

   // Next-state logic: restart overrides everything, then per-state rules.
   always_comb begin
      state_d      = state_q;
      winner_d     = winner_q;
      match_over_d = match_over_q;
      score_clr    = 1'b0;
      l_inc        = 1'b0;
      r_inc        = 1'b0;
      if (restart) begin
         score_clr    = 1'b1;
         winner_d     = WIN_NONE;
         match_over_d = 1'b0;
         state_d      = ROUND_END;
      end else begin
         case (state_q)
            PLAY: begin
               if (l_rise && r_rise) begin
                  state_d = ROUND_END;
               end else if (l_rise) begin
                  l_inc = 1'b1;
                  if ((left_bcd + 4'd1) == WIN_BCD) begin
                     winner_d     = WIN_LEFT;
                     match_over_d = 1'b1;
                     state_d      = MATCH_OVER;
                  end else begin
                     state_d = ROUND_END;
                  end
               end else if (r_rise) begin
                  r_inc = 1'b1;
                  if ((right_bcd + 4'd1) == WIN_BCD) begin
                     winner_d     = WIN_RIGHT;
                     match_over_d = 1'b1;
                     state_d      = MATCH_OVER;
                  end else begin
                     state_d = ROUND_END;
                  end
               end
            end
            ROUND_END: begin
               if (!left_win && !right_win) begin
                  state_d = PLAY;
               end
            end
            MATCH_OVER: begin
               state_d = MATCH_OVER;
            end
            default: begin
               state_d = PLAY;
            end
         endcase
      end
      // Registered copy of the Moore decode keeps round_rst glitch-free.
      round_rst_d = (state_d != PLAY);
   end

   // State, edge-detect and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= PLAY;
         l_prev_q     <= 1'b1;
         r_prev_q     <= 1'b1;
         winner_q     <= WIN_NONE;
         match_over_q <= 1'b0;
         round_rst_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         l_prev_q     <= left_win;
         r_prev_q     <= right_win;
         winner_q     <= winner_d;
         match_over_q <= match_over_d;
         round_rst_q  <= round_rst_d;
      end
   end

   bcd_digit u_left_digit (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (score_clr),
      .inc     (l_inc),
      .q       (left_bcd)
   );

   bcd_digit u_right_digit (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (score_clr),
      .inc     (r_inc),
      .q       (right_bcd)
   );

   assign round_rst  = round_rst_q;
   assign match_over = match_over_q;
   assign winner     = winner_q;

endmodule

// File: tb/tb_tow_score_counter.sv
// Bench for tow_score_counter: directed scenarios then random play against a round/match model.
module tb_tow_score_counter;

   localparam int unsigned TARGET = 7;

   logic       clk;
   logic       reset_n;
   logic       left_win;
   logic       right_win;
   logic       restart;
   logic [3:0] left_bcd;
   logic [3:0] right_bcd;
   logic       round_rst;
   logic       match_over;
   logic [1:0] winner;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: match progress as plain integers. phase 0 = live round, 1 = between rounds,
   // 2 = match decided.
   int         m_left, m_right, m_phase;
   logic [1:0] m_winner;
   logic       m_lseen, m_rseen;

   tow_score_counter #(
      .WIN_TARGET (TARGET)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .left_win   (left_win),
      .right_win  (right_win),
      .restart    (restart),
      .left_bcd   (left_bcd),
      .right_bcd  (right_bcd),
      .round_rst  (round_rst),
      .match_over (match_over),
      .winner     (winner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_left   = 0;
      m_right  = 0;
      m_phase  = 0;
      m_winner = 2'b00;
      m_lseen  = 1'b1;
      m_rseen  = 1'b1;
   endtask

   // One clock of match rules applied to the levels present at the edge.
   task automatic model_step(input logic l, input logic r, input logic rs);
      bit new_l, new_r;
      new_l = l && !m_lseen;
      new_r = r && !m_rseen;
      if (rs) begin
         m_left = 0; m_right = 0; m_winner = 2'b00; m_phase = 1;
      end else if (m_phase == 0) begin
         if (new_l && new_r) begin
            m_phase = 1;
         end else if (new_l) begin
            m_left = m_left + 1;
            if (m_left == TARGET) begin m_winner = 2'b10; m_phase = 2; end
            else m_phase = 1;
         end else if (new_r) begin
            m_right = m_right + 1;
            if (m_right == TARGET) begin m_winner = 2'b01; m_phase = 2; end
            else m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (!l && !r) m_phase = 0;
      end
      m_lseen = l;
      m_rseen = r;
   endtask

   task automatic expect_val(input string tag, input int got, input int exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      n_checks++;
      assert (left_bcd === 4'(m_left)) else begin
         n_fail++;
         $error("FAIL %s left_bcd: observed %0d expected %0d", tag, left_bcd, m_left);
      end
      n_checks++;
      assert (right_bcd === 4'(m_right)) else begin
         n_fail++;
         $error("FAIL %s right_bcd: observed %0d expected %0d", tag, right_bcd, m_right);
      end
      n_checks++;
      assert (round_rst === (m_phase != 0)) else begin
         n_fail++;
         $error("FAIL %s round_rst: observed %b expected %b", tag, round_rst, m_phase != 0);
      end
      n_checks++;
      assert (match_over === (m_phase == 2)) else begin
         n_fail++;
         $error("FAIL %s match_over: observed %b expected %b", tag, match_over, m_phase == 2);
      end
      n_checks++;
      assert (winner === m_winner) else begin
         n_fail++;
         $error("FAIL %s winner: observed %b expected %b", tag, winner, m_winner);
      end
      n_checks++;
      assert ((left_bcd <= 4'd9) && (right_bcd <= 4'd9)) else begin
         n_fail++;
         $error("FAIL %s bcd_range: observed %0d/%0d expected <=9", tag, left_bcd, right_bcd);
      end
   endtask

   // Called at a negedge: drive levels, take the edge, check 1 ns later, return at next negedge.
   task automatic cycle(input logic l, input logic r, input logic rs, input string tag);
      left_win  = l;
      right_win = r;
      restart   = rs;
      @(posedge clk);
      model_step(l, r, rs);
      #1;
      check_all(tag);
      @(negedge clk);
   endtask

   // Called at a negedge: assert reset between edges, check before the next edge, release later.
   task automatic async_reset(input string tag);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(posedge clk);
      #1;
      check_all(tag);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic round(input logic l, input logic r, input string tag);
      cycle(l, r, 1'b0, tag);
      cycle(1'b0, 1'b0, 1'b0, tag);
      cycle(1'b0, 1'b0, 1'b0, tag);
   endtask

   initial begin
      reset_n   = 1'b0;
      left_win  = 1'b1;
      right_win = 1'b0;
      restart   = 1'b0;
      model_reset();

      // 1. Reset with left_win already high; no count after release.
      @(negedge clk);
      check_all("reset");
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) cycle(1'b1, 1'b0, 1'b0, "held_after_reset");
      expect_val("no_count_held_win", left_bcd, 0);
      expect_val("play_after_reset", round_rst, 0);
      cycle(1'b0, 1'b0, 1'b0, "fall");

      // 2. Left wins one round with a 3-cycle level: single increment.
      cycle(1'b1, 1'b0, 1'b0, "left_rise");
      expect_val("left_one_after_rise", left_bcd, 1);
      cycle(1'b1, 1'b0, 1'b0, "left_hold");
      cycle(1'b1, 1'b0, 1'b0, "left_hold");
      expect_val("left_single_inc", left_bcd, 1);
      expect_val("round_rst_held", round_rst, 1);
      cycle(1'b0, 1'b0, 1'b0, "left_release");
      expect_val("round_rst_dropped", round_rst, 0);

      // 3. Tie.
      cycle(1'b1, 1'b1, 1'b0, "tie");
      expect_val("tie_left", left_bcd, 1);
      expect_val("tie_right", right_bcd, 0);
      expect_val("tie_round_rst", round_rst, 1);
      cycle(1'b0, 1'b0, 1'b0, "tie_release");
      cycle(1'b0, 1'b0, 1'b0, "tie_play");

      // 4. Right takes the match; an extra pulse changes nothing.
      repeat (TARGET) round(1'b0, 1'b1, "right_rounds");
      expect_val("right_final", right_bcd, TARGET);
      expect_val("match_over_set", match_over, 1);
      expect_val("winner_right", winner, 2'b01);
      round(1'b0, 1'b1, "right_extra");
      expect_val("right_frozen", right_bcd, TARGET);

      // 5. Restart during MATCH_OVER with a same-cycle left rise.
      cycle(1'b1, 1'b0, 1'b1, "restart");
      expect_val("restart_left", left_bcd, 0);
      expect_val("restart_right", right_bcd, 0);
      expect_val("restart_winner", winner, 2'b00);
      expect_val("restart_round_rst", round_rst, 1);
      cycle(1'b1, 1'b0, 1'b0, "restart_hold");
      cycle(1'b0, 1'b0, 1'b0, "restart_release");
      expect_val("restart_play", round_rst, 0);

      // 6. Async reset in ROUND_END with left at 3.
      round(1'b1, 1'b0, "left_r1");
      round(1'b1, 1'b0, "left_r2");
      cycle(1'b1, 1'b0, 1'b0, "left_r3");
      expect_val("left_three", left_bcd, 3);
      async_reset("async_reset");
      expect_val("async_left_zero", left_bcd, 0);

      // Random play with occasional restart and async reset.
      for (int i = 0; i < 600; i++) begin
         logic l, r, rs;
         l  = ($urandom_range(0, 99) < 35);
         r  = ($urandom_range(0, 99) < 30);
         rs = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 199) == 0) async_reset("rand_reset");
         else cycle(l, r, rs, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
